// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - RAS writer/controller: call/return pre-decode, push/pop pulses, return-prediction check.
// Optional statistics counters enabled by defining RAS_CTRL_STATS_EN.
module ras_ctrl #(
  parameter int XLEN       = 32,
  parameter int RETQ_DEPTH = 4,
  parameter int RETQ_PTR_W = $clog2(RETQ_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic                  if_stall,
  input  logic [XLEN-1:0]       if_pc,
  input  logic [31:0]           if_instr,
  input  logic                  flush,
  input  logic [XLEN-1:0]       ras_predicted_return,
  input  logic                  ras_valid,
  input  logic                  ex_ret_valid,
  input  logic [XLEN-1:0]       ex_ret_target,
  output logic                  push,
  output logic                  pop,
  output logic [XLEN-1:0]       return_addr,
  output logic                  ret_hit,
  output logic                  ret_mispredict,
  output logic [RETQ_PTR_W:0]   retq_count
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_calls,
  output logic [31:0]           stat_rets,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam logic [6:0]          OPC_JAL  = 7'b1101111;
  localparam logic [6:0]          OPC_JALR = 7'b1100111;
  localparam logic [RETQ_PTR_W:0] Q_FULL   = (RETQ_PTR_W+1)'(RETQ_DEPTH);

  logic       accept;
  logic [4:0] rd, rs1;
  logic       rd_link, rs1_link;
  logic       dec_push, dec_pop;
  logic       unused_instr_bits;

  assign accept   = if_valid & ~if_stall & ~flush;
  assign rd       = if_instr[11:7];
  assign rs1      = if_instr[19:15];
  assign rd_link  = (rd == 5'd1) | (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) | (rs1 == 5'd5);
  assign unused_instr_bits = ^{if_instr[31:20], if_instr[14:12]};

  // JALR with both operands linked but distinct is a co-routine swap (push and pop).
  always_comb begin
    dec_push = 1'b0;
    dec_pop  = 1'b0;
    case (if_instr[6:0])
      OPC_JAL:  dec_push = rd_link;
      OPC_JALR: begin
        dec_push = rd_link;
        dec_pop  = rs1_link & (~rd_link | (rd != rs1));
      end
      default: ;
    endcase
  end

  logic            push_q, pop_q;
  logic [XLEN-1:0] ret_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      ret_addr_q <= '0;
    end else begin
      push_q <= accept & dec_push;
      pop_q  <= accept & dec_pop;
      if (accept & dec_push)
        ret_addr_q <= if_pc + XLEN'(4);
    end
  end

  // A redirect kills the in-flight operation in its output cycle.
  assign push        = push_q & ~flush;
  assign pop         = pop_q & ~flush;
  assign return_addr = ret_addr_q;

  logic [XLEN-1:0]       q_target [RETQ_DEPTH];
  logic [RETQ_DEPTH-1:0] q_valid;
  logic [RETQ_PTR_W-1:0] rd_ptr, wr_ptr;
  logic [RETQ_PTR_W:0]   count, count_after_deq;
  logic                  deq, enq_ok, head_hit;

  assign deq             = ex_ret_valid & (count != '0);
  assign count_after_deq = count - {{RETQ_PTR_W{1'b0}}, deq};
  assign enq_ok          = pop & (count_after_deq != Q_FULL);
  assign head_hit        = q_valid[rd_ptr] & (q_target[rd_ptr] == ex_ret_target);
  assign retq_count      = count;

  always_ff @(posedge clk) begin
    if (enq_ok)
      q_target[wr_ptr] <= ras_predicted_return;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ret_hit        <= 1'b0;
      ret_mispredict <= 1'b0;
    end else begin
      ret_hit        <= deq & head_hit;
      ret_mispredict <= deq & ~head_hit;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (deq)
          rd_ptr <= rd_ptr + RETQ_PTR_W'(1);
        if (enq_ok) begin
          q_valid[wr_ptr] <= ras_valid;
          wr_ptr          <= wr_ptr + RETQ_PTR_W'(1);
        end
        count <= count_after_deq + {{RETQ_PTR_W{1'b0}}, enq_ok};
      end
    end
  end

`ifdef RAS_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_calls       <= '0;
      stat_rets        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (push && stat_calls != '1)
        stat_calls <= stat_calls + 32'd1;
      if ((ret_hit | ret_mispredict) && stat_rets != '1)
        stat_rets <= stat_rets + 32'd1;
      if (ret_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
